// File: rtl/score_pkg.sv
// Shared types and constants for the BCD score accumulator.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package score_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        ADD,
        COMMIT
    } acc_state_t;

    // Double-dabble: a nibble at or above 5 would exceed 9 after doubling,
    // so it is pre-biased by 3 to make the shift carry into the next nibble.
    localparam int BCD_ADJ_THRESH = 5;
    localparam int BCD_ADJ        = 3;
    localparam int BCD_MAX_DIGIT  = 9;

    // 10**n for elaboration-time range checks.
    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Single-digit BCD adder with carry in/out.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   a, b  : BCD digit operands (0-9)
//   cin   : carry from the less significant digit
//   sum   : BCD result digit (0-9)
//   cout  : carry into the next digit
module bcd_digit_adder
    import score_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t sum,
    output logic       cout
);

    logic [4:0] raw;
    logic [4:0] wrapped;

    always_comb begin
        raw     = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        wrapped = raw - 5'd10;
        if (raw > 5'(BCD_MAX_DIGIT)) begin
            sum  = wrapped[3:0];
            cout = 1'b1;
        end else begin
            sum  = raw[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/score_bcd_accumulator.sv
// Accumulates binary point increments into a saturating BCD score for the renderer.
// Latency: accept edge to commit edge is AMOUNT_W + DIGITS + 1 cycles.
// Backpressure: addReady low while an increment is in flight or clearScore is high.
//
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   addValid/Ready : increment handshake; addAmount sampled on accept
//   clearScore     : synchronous clear, overrides everything but reset
//   numbersToShow  : committed BCD score, digit 0 least significant
//   scoreUpdated   : one-cycle pulse whenever numbersToShow is rewritten
//   overflow       : sticky, set when an add saturates at all nines
module score_bcd_accumulator
    import score_pkg::*;
#(
    parameter int DIGITS   = 3,
    parameter int AMOUNT_W = 8
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    addValid,
    input  logic [AMOUNT_W-1:0]     addAmount,
    output logic                    addReady,
    input  logic                    clearScore,
    output logic [DIGITS-1:0][3:0]  numbersToShow,
    output logic                    scoreUpdated,
    output logic                    overflow
);

    localparam int BCW = (AMOUNT_W > 1) ? $clog2(AMOUNT_W) : 1;
    localparam int DGW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // The converter holds the whole increment in DIGITS nibbles, so the
    // largest binary amount must fit below 10**DIGITS.
    if (pow10(DIGITS) <= ((longint'(1) << AMOUNT_W) - 1)) begin : g_bad_params
        $error("score_bcd_accumulator: AMOUNT_W too wide for DIGITS");
    end

    acc_state_t                 state;
    acc_state_t                 state_nxt;
    logic [BCW-1:0]             bit_cnt;
    logic [DGW-1:0]             dig_idx;
    logic                       carry;
    logic [AMOUNT_W-1:0]        shift_q;
    bcd_digit_t [DIGITS-1:0]    amt_bcd;
    bcd_digit_t [DIGITS-1:0]    amt_adj;
    bcd_digit_t [DIGITS-1:0]    work;
    bcd_digit_t                 add_sum;
    logic                       add_cout;
    logic                       accept;
    logic                       last_bit;
    logic                       last_dig;

    assign accept   = addValid && addReady;
    assign last_bit = (bit_cnt == '0);
    assign last_dig = (dig_idx == DGW'(DIGITS - 1));

    // Next-state and handshake
    always_comb begin
        state_nxt = state;
        addReady  = (state == IDLE) && !clearScore;
        case (state)
            IDLE:    if (accept)   state_nxt = CONV;
            CONV:    if (last_bit) state_nxt = ADD;
            ADD:     if (last_dig) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clearScore) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Double-dabble bias applied before each shift
    always_comb begin
        amt_adj = amt_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (amt_bcd[i] >= 4'(BCD_ADJ_THRESH)) begin
                amt_adj[i] = amt_bcd[i] + 4'(BCD_ADJ);
            end
        end
    end

    bcd_digit_adder u_digit_adder (
        .a    (work[dig_idx]),
        .b    (amt_bcd[dig_idx]),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Datapath; numbersToShow is only written on commit or clear so the
    // renderer never sees a partially added score.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt       <= '0;
            dig_idx       <= '0;
            carry         <= 1'b0;
            shift_q       <= '0;
            amt_bcd       <= '0;
            work          <= '0;
            numbersToShow <= '0;
            scoreUpdated  <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            scoreUpdated <= 1'b0;
            if (clearScore) begin
                numbersToShow <= '0;
                overflow      <= 1'b0;
                scoreUpdated  <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            shift_q <= addAmount;
                            amt_bcd <= '0;
                            work    <= numbersToShow;
                            bit_cnt <= BCW'(AMOUNT_W - 1);
                        end
                    end
                    CONV: begin
                        {amt_bcd, shift_q} <= {amt_adj, shift_q} << 1;
                        bit_cnt            <= bit_cnt - BCW'(1);
                        if (last_bit) begin
                            dig_idx <= '0;
                            carry   <= 1'b0;
                        end
                    end
                    ADD: begin
                        work[dig_idx] <= add_sum;
                        carry         <= add_cout;
                        dig_idx       <= dig_idx + DGW'(1);
                    end
                    COMMIT: begin
                        // A carry out of the top digit means the true sum
                        // exceeds the display range: pin to all nines.
                        if (carry) begin
                            for (int i = 0; i < DIGITS; i++) begin
                                numbersToShow[i] <= 4'(BCD_MAX_DIGIT);
                            end
                            overflow <= 1'b1;
                        end else begin
                            numbersToShow <= work;
                        end
                        scoreUpdated <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_score_bcd_accumulator.sv
// Scoreboard bench for score_bcd_accumulator: model score kept as an integer.
// Latency: checks commit timing against accept edge + AMOUNT_W + DIGITS + 1.
// Backpressure: driver waits on addReady before each request.
module tb_score_bcd_accumulator;

    localparam int DIGITS   = 3;
    localparam int AMOUNT_W = 8;
    localparam int LAT      = AMOUNT_W + DIGITS + 1;
    localparam int PERIOD   = AMOUNT_W + DIGITS + 2;

    logic                   clk;
    logic                   reset;
    logic                   addValid;
    logic [AMOUNT_W-1:0]    addAmount;
    logic                   addReady;
    logic                   clearScore;
    logic [DIGITS-1:0][3:0] numbersToShow;
    logic                   scoreUpdated;
    logic                   overflow;

    score_bcd_accumulator #(.DIGITS(DIGITS), .AMOUNT_W(AMOUNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .addValid      (addValid),
        .addAmount     (addAmount),
        .addReady      (addReady),
        .clearScore    (clearScore),
        .numbersToShow (numbersToShow),
        .scoreUpdated  (scoreUpdated),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int score;
        bit ovf;
        int due;
    } exp_t;

    exp_t q[$];
    int   nchk  = 0;
    int   nfail = 0;
    int   mscore = 0;
    bit   movf   = 1'b0;
    int   maxscore;

    initial maxscore = 1;
    initial for (int i = 0; i < DIGITS; i++) maxscore = maxscore * 10;

    task automatic chk(input string nm, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DIGITS*4-1:0] to_bcd(input int v);
        logic [DIGITS*4-1:0] r;
        int t;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Monitor: every update pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!reset && scoreUpdated) begin
            if (q.size() == 0) begin
                chk("unexpected_update", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("score", longint'(numbersToShow), longint'(to_bcd(e.score)));
                chk("overflow", longint'(overflow), longint'(e.ovf));
                chk("commit_cycle", cyc, e.due);
            end
        end
    end

    // Entry and exit at a falling edge.
    task automatic do_add(input int amt, input bit hold, output int acc_cyc);
        int n;
        exp_t e;
        addAmount = AMOUNT_W'(amt);
        addValid  = 1'b1;
        n = 0;
        while (!addReady && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!addReady) begin
            chk("ready_timeout", 0, 1);
            addValid = 1'b0;
            acc_cyc  = cyc;
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (mscore + amt >= maxscore) begin
            mscore = maxscore - 1;
            movf   = 1'b1;
        end else begin
            mscore = mscore + amt;
        end
        e.score = mscore;
        e.ovf   = movf;
        e.due   = acc_cyc + LAT;
        q.push_back(e);
        chk("ready_drop_on_accept", longint'(addReady), 0);
        @(negedge clk);
        if (!hold) addValid = 1'b0;
        addAmount = AMOUNT_W'($urandom);
    endtask

    task automatic do_clear();
        exp_t e;
        #2;
        addValid   = 1'b0;
        q.delete();
        mscore     = 0;
        movf       = 1'b0;
        e.score    = 0;
        e.ovf      = 1'b0;
        e.due      = cyc + 1;
        q.push_back(e);
        clearScore = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clearScore = 1'b0;
        #1;
        chk("idle_after_clear", longint'(addReady), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            chk("commit_timeout", q.size(), 0);
            q.delete();
        end
        @(negedge clk);
        chk("pulse_width", longint'(scoreUpdated), 0);
    endtask

    initial begin
        int t1, t2, tx;
        reset      = 1'b1;
        addValid   = 1'b0;
        addAmount  = '0;
        clearScore = 1'b0;
        #1;
        chk("rst_score", longint'(numbersToShow), 0);
        chk("rst_overflow", longint'(overflow), 0);
        chk("rst_updated", longint'(scoreUpdated), 0);
        chk("rst_ready", longint'(addReady), 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single add
        do_add(7, 0, tx);
        wait_idle();

        // Back-to-back with addValid held
        do_clear();
        wait_idle();
        do_add(255, 1, t1);
        do_add(255, 0, t2);
        chk("b2b_spacing", t2 - t1, PERIOD);
        wait_idle();

        // Carry chains
        do_clear();
        wait_idle();
        do_add(99, 0, tx);  wait_idle();
        do_add(1, 0, tx);   wait_idle();
        do_add(99, 0, tx);  wait_idle();
        do_add(255, 0, tx); wait_idle();

        // Saturation then zero add
        do_clear();
        wait_idle();
        do_add(255, 0, tx); wait_idle();
        do_add(255, 0, tx); wait_idle();
        do_add(255, 0, tx); wait_idle();
        do_add(225, 0, tx); wait_idle();
        do_add(255, 0, tx); wait_idle();
        do_add(0, 0, tx);   wait_idle();

        // Clear during the 4th conversion cycle of an add of 200 onto 050
        do_clear();
        wait_idle();
        do_add(50, 0, tx); wait_idle();
        do_add(200, 0, tx);
        repeat (3) @(negedge clk);
        do_clear();
        wait_idle();
        repeat (16) @(negedge clk);
        chk("discarded_add", longint'(numbersToShow), 0);

        // Async reset mid-ADD
        do_add(40, 0, tx); wait_idle();
        do_add(77, 0, tx);
        repeat (9) @(negedge clk);
        #3;
        reset = 1'b1;
        #1;
        q.delete();
        mscore = 0;
        movf   = 1'b0;
        chk("async_rst_score", longint'(numbersToShow), 0);
        chk("async_rst_overflow", longint'(overflow), 0);
        chk("async_rst_updated", longint'(scoreUpdated), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_add(3, 0, tx);
        wait_idle();

        // Randomized mix of adds and clears
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                do_clear();
            end else begin
                do_add(int'($urandom_range(0, 150)), 0, tx);
            end
            if ($urandom_range(0, 2) == 0) wait_idle();
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
